// File: rtl/datapath_pipelined.sv
// Two-stage CR16-style datapath: operand read (RD) feeding an execute/writeback
// (EX) stage that owns the register file, flag register and registered result.
// EX results are forwarded back into the RD operand muxes, so back-to-back
// dependent instructions issue without bubbles.
module datapath_pipelined #(
  parameter int DATA_WIDTH = 16,
  parameter int REG_COUNT = 16,
  localparam int REG_SEL_WIDTH = $clog2(REG_COUNT)
) (
  input  logic                     I_CLK,
  input  logic                     I_RESET,
  input  logic                     I_VALID,
  input  logic                     I_STALL,
  input  logic [3:0]               I_OPCODE,
  input  logic [REG_SEL_WIDTH-1:0] I_SRC_A,
  input  logic [REG_SEL_WIDTH-1:0] I_SRC_B,
  input  logic [REG_SEL_WIDTH-1:0] I_DEST,
  input  logic                     I_IMMEDIATE_SELECT,
  input  logic [DATA_WIDTH-1:0]    I_IMMEDIATE,
  input  logic                     I_WRITE_ENABLE,
  input  logic                     I_FLAGS_ENABLE,
  output logic [DATA_WIDTH-1:0]    O_RESULT,
  output logic                     O_RESULT_VALID,
  output logic [REG_SEL_WIDTH-1:0] O_RESULT_DEST,
  output logic [4:0]               O_FLAGS
);

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_CMP = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_MOV = 4'd6,
    OP_SHL = 4'd7,
    OP_SHR = 4'd8
  } opcode_e;

  // Flag register bit positions, {C,L,F,Z,N}
  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;
  localparam int MSB = DATA_WIDTH - 1;

  // EX stage register
  logic                     exValid_q;
  opcode_e                  exOp_q;
  logic [DATA_WIDTH-1:0]    exA_q;
  logic [DATA_WIDTH-1:0]    exB_q;
  logic [REG_SEL_WIDTH-1:0] exDest_q;
  logic                     exWe_q;
  logic                     exFe_q;

  // Architectural state
  logic [DATA_WIDTH-1:0]    regs_q [REG_COUNT];
  logic [4:0]               flags_q;
  logic [4:0]               flags_d;
  logic [DATA_WIDTH-1:0]    result_q;
  logic                     resultValid_q;
  logic [REG_SEL_WIDTH-1:0] resultDest_q;

  // ALU and forwarding signals
  logic [DATA_WIDTH-1:0]    aluResult;
  logic                     aluWritesBack;
  logic                     aluUpdatesFlags;
  logic [DATA_WIDTH:0]      sumExt;
  logic [DATA_WIDTH:0]      diffExt;
  logic                     retire;
  logic                     exWritesReg;
  logic [DATA_WIDTH-1:0]    opA_d;
  logic [DATA_WIDTH-1:0]    opB_d;

  assign sumExt  = {1'b0, exB_q} + {1'b0, exA_q};
  assign diffExt = {1'b0, exB_q} - {1'b0, exA_q};

  // The EX instruction completes on any edge where the pipe is not frozen
  assign retire      = exValid_q && !I_STALL;
  assign exWritesReg = exValid_q && exWe_q && aluWritesBack;

  // ALU: result, writeback qualification and candidate flag values
  always_comb begin
    aluResult       = '0;
    aluWritesBack   = 1'b0;
    aluUpdatesFlags = 1'b1;
    flags_d         = flags_q;
    case (exOp_q)
      OP_ADD: begin
        aluResult       = sumExt[DATA_WIDTH-1:0];
        aluWritesBack   = 1'b1;
        flags_d[FLAG_C] = sumExt[DATA_WIDTH];
        flags_d[FLAG_F] = (exA_q[MSB] == exB_q[MSB]) && (aluResult[MSB] != exB_q[MSB]);
        flags_d[FLAG_Z] = (aluResult == '0);
        flags_d[FLAG_N] = aluResult[MSB];
      end
      OP_SUB, OP_CMP: begin
        aluResult       = diffExt[DATA_WIDTH-1:0];
        aluWritesBack   = (exOp_q == OP_SUB);
        flags_d[FLAG_C] = diffExt[DATA_WIDTH];
        flags_d[FLAG_F] = (exA_q[MSB] != exB_q[MSB]) && (aluResult[MSB] != exB_q[MSB]);
        flags_d[FLAG_L] = (exB_q < exA_q);
        flags_d[FLAG_N] = ($signed(exB_q) < $signed(exA_q));
        flags_d[FLAG_Z] = (exB_q == exA_q);
      end
      OP_AND, OP_OR, OP_XOR, OP_MOV, OP_SHL, OP_SHR: begin
        case (exOp_q)
          OP_AND:  aluResult = exB_q & exA_q;
          OP_OR:   aluResult = exB_q | exA_q;
          OP_XOR:  aluResult = exB_q ^ exA_q;
          OP_MOV:  aluResult = exA_q;
          // Shift amounts at or beyond the width shift everything out, giving 0
          OP_SHL:  aluResult = exB_q << exA_q;
          OP_SHR:  aluResult = exB_q >> exA_q;
          default: aluResult = '0;
        endcase
        aluWritesBack   = 1'b1;
        flags_d[FLAG_Z] = (aluResult == '0);
        flags_d[FLAG_N] = aluResult[MSB];
      end
      default: begin
        aluResult       = '0;
        aluWritesBack   = 1'b0;
        aluUpdatesFlags = 1'b0;
      end
    endcase
  end

  // RD operand muxes: immediate, forwarded EX result, or register file
  always_comb begin
    if (I_IMMEDIATE_SELECT) begin
      opA_d = I_IMMEDIATE;
    end else if (exWritesReg && (exDest_q == I_SRC_A)) begin
      opA_d = aluResult;
    end else begin
      opA_d = regs_q[I_SRC_A];
    end
    if (exWritesReg && (exDest_q == I_SRC_B)) begin
      opB_d = aluResult;
    end else begin
      opB_d = regs_q[I_SRC_B];
    end
  end

  // RD/EX stage register: loads a new instruction unless the pipe is stalled
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      exValid_q <= 1'b0;
      exOp_q    <= OP_ADD;
      exA_q     <= '0;
      exB_q     <= '0;
      exDest_q  <= '0;
      exWe_q    <= 1'b0;
      exFe_q    <= 1'b0;
    end else if (!I_STALL) begin
      exValid_q <= I_VALID;
      if (I_VALID) begin
        exOp_q   <= opcode_e'(I_OPCODE);
        exA_q    <= opA_d;
        exB_q    <= opB_d;
        exDest_q <= I_DEST;
        exWe_q   <= I_WRITE_ENABLE;
        exFe_q   <= I_FLAGS_ENABLE;
      end
    end
  end

  // Register file writeback from the retiring instruction
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
    end else if (retire && exWritesReg) begin
      regs_q[exDest_q] <= aluResult;
    end
  end

  // Flag register update from the retiring instruction
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      flags_q <= '0;
    end else if (retire && exFe_q && aluUpdatesFlags) begin
      flags_q <= flags_d;
    end
  end

  // Registered result port with a one-cycle valid pulse per retirement
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      result_q      <= '0;
      resultValid_q <= 1'b0;
      resultDest_q  <= '0;
    end else begin
      resultValid_q <= retire;
      if (retire) begin
        result_q     <= aluResult;
        resultDest_q <= exDest_q;
      end
    end
  end

  assign O_RESULT       = result_q;
  assign O_RESULT_VALID = resultValid_q;
  assign O_RESULT_DEST  = resultDest_q;
  assign O_FLAGS        = flags_q;

endmodule

// File: tb/tb_datapath_pipelined.sv
// Directed bench for datapath_pipelined: a default 16-bit instance plus a
// 32-bit / 8-register instance, each scenario checked against hand-computed values.
module tb_datapath_pipelined;

  logic clock;
  logic reset;

  // 16-bit instance signals
  logic        valid16, stall16, isel16, we16, fe16;
  logic [3:0]  op16, srcA16, srcB16, dest16;
  logic [15:0] imm16;
  logic [15:0] result16;
  logic        resultValid16;
  logic [3:0]  resultDest16;
  logic [4:0]  flags16;

  // 32-bit instance signals
  logic        valid32, stall32, isel32, we32, fe32;
  logic [3:0]  op32;
  logic [2:0]  srcA32, srcB32, dest32;
  logic [31:0] imm32;
  logic [31:0] result32;
  logic        resultValid32;
  logic [2:0]  resultDest32;
  logic [4:0]  flags32;

  int applied;
  int miscompares;
  logic [15:0] rd16;
  logic [31:0] rd32;

  datapath_pipelined dut16 (
    .I_CLK(clock), .I_RESET(reset), .I_VALID(valid16), .I_STALL(stall16),
    .I_OPCODE(op16), .I_SRC_A(srcA16), .I_SRC_B(srcB16), .I_DEST(dest16),
    .I_IMMEDIATE_SELECT(isel16), .I_IMMEDIATE(imm16),
    .I_WRITE_ENABLE(we16), .I_FLAGS_ENABLE(fe16),
    .O_RESULT(result16), .O_RESULT_VALID(resultValid16),
    .O_RESULT_DEST(resultDest16), .O_FLAGS(flags16)
  );

  datapath_pipelined #(.DATA_WIDTH(32), .REG_COUNT(8)) dut32 (
    .I_CLK(clock), .I_RESET(reset), .I_VALID(valid32), .I_STALL(stall32),
    .I_OPCODE(op32), .I_SRC_A(srcA32), .I_SRC_B(srcB32), .I_DEST(dest32),
    .I_IMMEDIATE_SELECT(isel32), .I_IMMEDIATE(imm32),
    .I_WRITE_ENABLE(we32), .I_FLAGS_ENABLE(fe32),
    .O_RESULT(result32), .O_RESULT_VALID(resultValid32),
    .O_RESULT_DEST(resultDest32), .O_FLAGS(flags32)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive16(input logic [3:0] op, input logic [3:0] sa, input logic [3:0] sb,
                         input logic [3:0] d, input logic isel, input logic [15:0] imm,
                         input logic we, input logic fe);
    valid16 = 1'b1; op16 = op; srcA16 = sa; srcB16 = sb; dest16 = d;
    isel16 = isel; imm16 = imm; we16 = we; fe16 = fe;
  endtask

  task automatic drive32(input logic [3:0] op, input logic [2:0] sa, input logic [2:0] sb,
                         input logic [2:0] d, input logic isel, input logic [31:0] imm,
                         input logic we, input logic fe);
    valid32 = 1'b1; op32 = op; srcA32 = sa; srcB32 = sb; dest32 = d;
    isel32 = isel; imm32 = imm; we32 = we; fe32 = fe;
  endtask

  // Read a register through the ALU: OR with immediate 0, no write, no flags
  task automatic read16(input logic [3:0] r, output logic [15:0] val);
    drive16(4'd4, 4'd0, r, 4'd0, 1'b1, 16'h0000, 1'b0, 1'b0);
    tick();
    valid16 = 1'b0;
    tick();
    val = result16;
  endtask

  task automatic read32(input logic [2:0] r, output logic [31:0] val);
    drive32(4'd4, 3'd0, r, 3'd0, 1'b1, 32'h0, 1'b0, 1'b0);
    tick();
    valid32 = 1'b0;
    tick();
    val = result32;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    applied++; if (result16 !== 16'h0) begin miscompares++; $display("[TB] FAIL reset_result: got %h expected %h", result16, 16'h0); end
    applied++; if (resultValid16 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %b expected %b", resultValid16, 1'b0); end
    applied++; if (resultDest16 !== 4'h0) begin miscompares++; $display("[TB] FAIL reset_dest: got %h expected %h", resultDest16, 4'h0); end
    applied++; if (flags16 !== 5'b0) begin miscompares++; $display("[TB] FAIL reset_flags: got %b expected %b", flags16, 5'b0); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    drive16(4'd6, 4'd0, 4'd0, 4'd1, 1'b1, 16'd5, 1'b1, 1'b1);
    tick();
    drive16(4'd0, 4'd1, 4'd1, 4'd2, 1'b0, 16'd0, 1'b1, 1'b1);
    tick();
    applied++; if (result16 !== 16'd5) begin miscompares++; $display("[TB] FAIL b2b_mov_result: got %h expected %h", result16, 16'd5); end
    applied++; if (resultValid16 !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_mov_valid: got %b expected %b", resultValid16, 1'b1); end
    applied++; if (resultDest16 !== 4'd1) begin miscompares++; $display("[TB] FAIL b2b_mov_dest: got %h expected %h", resultDest16, 4'd1); end
    valid16 = 1'b0;
    tick();
    applied++; if (result16 !== 16'd10) begin miscompares++; $display("[TB] FAIL b2b_add_result: got %h expected %h", result16, 16'd10); end
    applied++; if (resultDest16 !== 4'd2) begin miscompares++; $display("[TB] FAIL b2b_add_dest: got %h expected %h", resultDest16, 4'd2); end
    applied++; if (resultValid16 !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_add_valid: got %b expected %b", resultValid16, 1'b1); end
    applied++; if (flags16 !== 5'b00000) begin miscompares++; $display("[TB] FAIL b2b_add_flags: got %b expected %b", flags16, 5'b00000); end
    tick();
    applied++; if (resultValid16 !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_idle_valid: got %b expected %b", resultValid16, 1'b0); end
    read16(4'd2, rd16);
    applied++; if (rd16 !== 16'd10) begin miscompares++; $display("[TB] FAIL b2b_r2: got %h expected %h", rd16, 16'd10); end
  endtask

  task automatic test_sub_cmp();
    drive16(4'd6, 4'd0, 4'd0, 4'd1, 1'b1, 16'd3, 1'b1, 1'b0);
    tick();
    drive16(4'd6, 4'd0, 4'd0, 4'd2, 1'b1, 16'd5, 1'b1, 1'b0);
    tick();
    drive16(4'd2, 4'd2, 4'd1, 4'd1, 1'b0, 16'd0, 1'b1, 1'b1);
    tick();
    valid16 = 1'b0;
    tick();
    applied++; if (flags16 !== 5'b11001) begin miscompares++; $display("[TB] FAIL cmp_flags: got %b expected %b", flags16, 5'b11001); end
    applied++; if (resultValid16 !== 1'b1) begin miscompares++; $display("[TB] FAIL cmp_valid: got %b expected %b", resultValid16, 1'b1); end
    applied++; if (resultDest16 !== 4'd1) begin miscompares++; $display("[TB] FAIL cmp_dest: got %h expected %h", resultDest16, 4'd1); end
    read16(4'd1, rd16);
    applied++; if (rd16 !== 16'd3) begin miscompares++; $display("[TB] FAIL cmp_r1_kept: got %h expected %h", rd16, 16'd3); end
    drive16(4'd1, 4'd1, 4'd2, 4'd4, 1'b0, 16'd0, 1'b1, 1'b1);
    tick();
    valid16 = 1'b0;
    tick();
    applied++; if (result16 !== 16'd2) begin miscompares++; $display("[TB] FAIL sub_result: got %h expected %h", result16, 16'd2); end
    applied++; if (flags16 !== 5'b00000) begin miscompares++; $display("[TB] FAIL sub_flags: got %b expected %b", flags16, 5'b00000); end
  endtask

  task automatic test_overflow();
    drive16(4'd6, 4'd0, 4'd0, 4'd5, 1'b1, 16'h7FFF, 1'b1, 1'b0);
    tick();
    drive16(4'd0, 4'd0, 4'd5, 4'd6, 1'b1, 16'h0001, 1'b1, 1'b1);
    tick();
    valid16 = 1'b0;
    tick();
    applied++; if (result16 !== 16'h8000) begin miscompares++; $display("[TB] FAIL ovf_result: got %h expected %h", result16, 16'h8000); end
    applied++; if (flags16 !== 5'b00101) begin miscompares++; $display("[TB] FAIL ovf_flags: got %b expected %b", flags16, 5'b00101); end
    drive16(4'd6, 4'd0, 4'd0, 4'd5, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    tick();
    drive16(4'd0, 4'd0, 4'd5, 4'd6, 1'b1, 16'h0001, 1'b1, 1'b1);
    tick();
    valid16 = 1'b0;
    tick();
    applied++; if (result16 !== 16'h0000) begin miscompares++; $display("[TB] FAIL carry_result: got %h expected %h", result16, 16'h0000); end
    applied++; if (flags16 !== 5'b10010) begin miscompares++; $display("[TB] FAIL carry_flags: got %b expected %b", flags16, 5'b10010); end
  endtask

  task automatic test_reserved_and_flag_hold();
    read16(4'd5, rd16);
    applied++; if (rd16 !== 16'hFFFF) begin miscompares++; $display("[TB] FAIL r5_before: got %h expected %h", rd16, 16'hFFFF); end
    drive16(4'd9, 4'd0, 4'd0, 4'd5, 1'b1, 16'h1234, 1'b1, 1'b1);
    tick();
    valid16 = 1'b0;
    tick();
    applied++; if (result16 !== 16'h0000) begin miscompares++; $display("[TB] FAIL rsvd_result: got %h expected %h", result16, 16'h0000); end
    applied++; if (resultValid16 !== 1'b1) begin miscompares++; $display("[TB] FAIL rsvd_valid: got %b expected %b", resultValid16, 1'b1); end
    applied++; if (flags16 !== 5'b10010) begin miscompares++; $display("[TB] FAIL rsvd_flags: got %b expected %b", flags16, 5'b10010); end
    read16(4'd5, rd16);
    applied++; if (rd16 !== 16'hFFFF) begin miscompares++; $display("[TB] FAIL rsvd_no_write: got %h expected %h", rd16, 16'hFFFF); end
    drive16(4'd0, 4'd0, 4'd5, 4'd6, 1'b1, 16'h0002, 1'b1, 1'b0);
    tick();
    valid16 = 1'b0;
    tick();
    applied++; if (result16 !== 16'h0001) begin miscompares++; $display("[TB] FAIL fhold_result: got %h expected %h", result16, 16'h0001); end
    applied++; if (flags16 !== 5'b10010) begin miscompares++; $display("[TB] FAIL fhold_flags: got %b expected %b", flags16, 5'b10010); end
  endtask

  task automatic test_stall();
    drive16(4'd0, 4'd0, 4'd1, 4'd8, 1'b1, 16'h0010, 1'b1, 1'b0);
    tick();
    stall16 = 1'b1;
    drive16(4'd6, 4'd0, 4'd0, 4'd9, 1'b1, 16'h00AA, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      applied++; if (resultValid16 !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_valid_%0d: got %b expected %b", i, resultValid16, 1'b0); end
      applied++; if (result16 !== 16'h0001) begin miscompares++; $display("[TB] FAIL stall_hold_%0d: got %h expected %h", i, result16, 16'h0001); end
    end
    stall16 = 1'b0;
    valid16 = 1'b0;
    tick();
    applied++; if (resultValid16 !== 1'b1) begin miscompares++; $display("[TB] FAIL release_valid: got %b expected %b", resultValid16, 1'b1); end
    applied++; if (result16 !== 16'h0013) begin miscompares++; $display("[TB] FAIL release_result: got %h expected %h", result16, 16'h0013); end
    applied++; if (resultDest16 !== 4'd8) begin miscompares++; $display("[TB] FAIL release_dest: got %h expected %h", resultDest16, 4'd8); end
    tick();
    applied++; if (resultValid16 !== 1'b0) begin miscompares++; $display("[TB] FAIL release_single: got %b expected %b", resultValid16, 1'b0); end
    read16(4'd9, rd16);
    applied++; if (rd16 !== 16'h0000) begin miscompares++; $display("[TB] FAIL stall_ignored_r9: got %h expected %h", rd16, 16'h0000); end
    read16(4'd8, rd16);
    applied++; if (rd16 !== 16'h0013) begin miscompares++; $display("[TB] FAIL stall_r8: got %h expected %h", rd16, 16'h0013); end
  endtask

  task automatic test_param32();
    drive32(4'd6, 3'd0, 3'd0, 3'd1, 1'b1, 32'd1, 1'b1, 1'b0);
    tick();
    drive32(4'd7, 3'd0, 3'd1, 3'd7, 1'b1, 32'd31, 1'b1, 1'b1);
    tick();
    valid32 = 1'b0;
    tick();
    applied++; if (result32 !== 32'h80000000) begin miscompares++; $display("[TB] FAIL shl31_result: got %h expected %h", result32, 32'h80000000); end
    applied++; if (resultDest32 !== 3'd7) begin miscompares++; $display("[TB] FAIL shl31_dest: got %h expected %h", resultDest32, 3'd7); end
    applied++; if (flags32 !== 5'b00001) begin miscompares++; $display("[TB] FAIL shl31_flags: got %b expected %b", flags32, 5'b00001); end
    drive32(4'd7, 3'd0, 3'd7, 3'd6, 1'b1, 32'd40, 1'b1, 1'b1);
    tick();
    valid32 = 1'b0;
    tick();
    applied++; if (result32 !== 32'h0) begin miscompares++; $display("[TB] FAIL shl40_result: got %h expected %h", result32, 32'h0); end
    applied++; if (flags32 !== 5'b00010) begin miscompares++; $display("[TB] FAIL shl40_flags: got %b expected %b", flags32, 5'b00010); end
    drive32(4'd8, 3'd0, 3'd7, 3'd5, 1'b1, 32'd31, 1'b1, 1'b0);
    tick();
    valid32 = 1'b0;
    tick();
    applied++; if (result32 !== 32'h1) begin miscompares++; $display("[TB] FAIL shr31_result: got %h expected %h", result32, 32'h1); end
    read32(3'd7, rd32);
    applied++; if (rd32 !== 32'h80000000) begin miscompares++; $display("[TB] FAIL r7_readback: got %h expected %h", rd32, 32'h80000000); end
  endtask

  task automatic test_reset_midstream();
    drive16(4'd6, 4'd0, 4'd0, 4'd3, 1'b1, 16'h0055, 1'b1, 1'b1);
    tick();
    valid16 = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    applied++; if (result16 !== 16'h0) begin miscompares++; $display("[TB] FAIL midrst_result: got %h expected %h", result16, 16'h0); end
    applied++; if (resultDest16 !== 4'h0) begin miscompares++; $display("[TB] FAIL midrst_dest: got %h expected %h", resultDest16, 4'h0); end
    applied++; if (flags16 !== 5'b0) begin miscompares++; $display("[TB] FAIL midrst_flags: got %b expected %b", flags16, 5'b0); end
    tick();
    applied++; if (resultValid16 !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_valid: got %b expected %b", resultValid16, 1'b0); end
    reset = 1'b0;
    read16(4'd3, rd16);
    applied++; if (rd16 !== 16'h0) begin miscompares++; $display("[TB] FAIL midrst_r3: got %h expected %h", rd16, 16'h0); end
    read16(4'd8, rd16);
    applied++; if (rd16 !== 16'h0) begin miscompares++; $display("[TB] FAIL midrst_r8: got %h expected %h", rd16, 16'h0); end
  endtask

  initial begin
    applied = 0;
    miscompares = 0;
    reset = 1'b1;
    valid16 = 1'b0; stall16 = 1'b0; op16 = '0; srcA16 = '0; srcB16 = '0; dest16 = '0;
    isel16 = 1'b0; imm16 = '0; we16 = 1'b0; fe16 = 1'b0;
    valid32 = 1'b0; stall32 = 1'b0; op32 = '0; srcA32 = '0; srcB32 = '0; dest32 = '0;
    isel32 = 1'b0; imm32 = '0; we32 = 1'b0; fe32 = 1'b0;
    $display("[TB] starting datapath_pipelined directed tests");
    test_reset();
    test_back_to_back();
    test_sub_cmp();
    test_overflow();
    test_reserved_and_flag_hold();
    test_stall();
    test_param32();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
